// File: rtl/mem_pkg.sv
// Shared types for the memory-access stage.
//   cmd_e   : command encoding carried in from EX/MEM.
//   state_e : mem_stage FSM states (also driven out on the debug port).
//   wb_t    : trace-level view of the MEM/WB bundle at the default widths.
package mem_pkg;

  localparam int MEM_DATA_W = 32;
  localparam int MEM_REG_W  = 5;

  typedef enum logic [1:0] {
    CMD_ALU   = 2'b00,
    CMD_LOAD  = 2'b01,
    CMD_STORE = 2'b10,
    CMD_RSVD  = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10
  } state_e;

  typedef struct packed {
    logic                  valid;
    logic                  we;
    logic [MEM_REG_W-1:0]  reg_dst;
    logic [MEM_DATA_W-1:0] data;
    logic [31:0]           instr;
  } wb_t;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   retire                : an instruction retires this cycle
//   we_d, err_d           : write enable / error flag for the retiring instruction
//   reg_dst_d, data_d,
//   instr_d               : writeback payload
//   wb_valid, wb_we,
//   err_o                 : one-cycle pulses, only high on the cycle after retire
//   wb_reg_dst, wb_data,
//   wb_instr              : payload, held between retirements
module mem_wb_reg #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              retire,
  input  logic              we_d,
  input  logic              err_d,
  input  logic [REG_W-1:0]  reg_dst_d,
  input  logic [DATA_W-1:0] data_d,
  input  logic [31:0]       instr_d,
  output logic              wb_valid,
  output logic              wb_we,
  output logic              err_o,
  output logic [REG_W-1:0]  wb_reg_dst,
  output logic [DATA_W-1:0] wb_data,
  output logic [31:0]       wb_instr
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid   <= 1'b0;
      wb_we      <= 1'b0;
      err_o      <= 1'b0;
      wb_reg_dst <= '0;
      wb_data    <= '0;
      wb_instr   <= '0;
    end else begin
      // Pulses are gated by retire so they can never stretch past one cycle.
      wb_valid <= retire;
      wb_we    <= retire & we_d;
      err_o    <= retire & err_d;
      if (retire) begin
        wb_reg_dst <= reg_dst_d;
        wb_data    <= data_d;
        wb_instr   <= instr_d;
      end
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage (EX/MEM -> MEM/WB).
// ALU-only instructions retire in one cycle; aligned loads/stores go out on
// the data-memory request channel while stall_o holds the upstream stages.
// Handshake: a request transfers on a cycle where dmem_req_valid and
// dmem_req_ready are both high; valid, addr, wdata and we stay stable until
// then. The response channel is valid-only and is honoured solely in WAIT.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid, alu_result, reg2, reg_dst, instr, alu_write, cmd_type : EX/MEM slot
//   stall_o             : stage busy, upstream must hold
//   dmem_req_*          : request channel (valid/ready)
//   dmem_resp_*         : response channel (valid only)
//   wb_*                : registered writeback bundle
//   err_o               : pulse on misaligned access, reserved command or timeout
//   dbg_state           : current FSM state
module mem_stage
  import mem_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int REG_W   = 5,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] reg2,
  input  logic [REG_W-1:0]  reg_dst,
  input  logic [31:0]       instr,
  input  logic              alu_write,
  input  logic [1:0]        cmd_type,
  output logic              stall_o,
  output logic              dmem_req_valid,
  input  logic              dmem_req_ready,
  output logic              dmem_req_we,
  output logic [DATA_W-1:0] dmem_req_addr,
  output logic [DATA_W-1:0] dmem_req_wdata,
  input  logic              dmem_resp_valid,
  input  logic [DATA_W-1:0] dmem_resp_rdata,
  output logic              wb_valid,
  output logic              wb_we,
  output logic [REG_W-1:0]  wb_reg_dst,
  output logic [DATA_W-1:0] wb_data,
  output logic [31:0]       wb_instr,
  output logic              err_o,
  output state_e            dbg_state
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_e            state, state_nxt;
  cmd_e              cmd;
  logic              misaligned;
  logic              capture, cnt_clr, cnt_inc;
  logic              ret_valid, ret_we, ret_err;
  logic [REG_W-1:0]  ret_reg_dst;
  logic [DATA_W-1:0] ret_data;
  logic [31:0]       ret_instr;
  logic [DATA_W-1:0] hold_addr, hold_wdata;
  logic [REG_W-1:0]  hold_reg_dst;
  logic [31:0]       hold_instr;
  logic              hold_we;
  logic [CNT_W-1:0]  cnt;

  assign cmd        = cmd_e'(cmd_type);
  assign misaligned = (alu_result[1:0] != 2'b00);

  assign stall_o        = (state != ST_IDLE);
  assign dmem_req_valid = (state == ST_REQ);
  assign dmem_req_we    = hold_we;
  assign dmem_req_addr  = hold_addr;
  assign dmem_req_wdata = hold_wdata;
  assign dbg_state      = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    capture     = 1'b0;
    cnt_clr     = 1'b0;
    cnt_inc     = 1'b0;
    ret_valid   = 1'b0;
    ret_we      = 1'b0;
    ret_err     = 1'b0;
    ret_reg_dst = hold_reg_dst;
    ret_data    = hold_addr;
    ret_instr   = hold_instr;
    unique case (state)
      ST_IDLE: begin
        if (in_valid) begin
          if (cmd == CMD_ALU) begin
            ret_valid   = 1'b1;
            ret_we      = alu_write && (reg_dst != '0);
            ret_reg_dst = reg_dst;
            ret_data    = alu_result;
            ret_instr   = instr;
          end else if (cmd == CMD_RSVD || misaligned) begin
            // Rejected without touching memory; retires as a non-writing error.
            ret_valid   = 1'b1;
            ret_err     = 1'b1;
            ret_reg_dst = reg_dst;
            ret_data    = alu_result;
            ret_instr   = instr;
          end else begin
            capture   = 1'b1;
            state_nxt = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (dmem_req_ready) begin
          if (hold_we) begin
            ret_valid = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            cnt_clr   = 1'b1;
            state_nxt = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        // A response on the deadline cycle still wins over the timeout.
        if (dmem_resp_valid) begin
          ret_valid = 1'b1;
          ret_we    = (hold_reg_dst != '0);
          ret_data  = dmem_resp_rdata;
          state_nxt = ST_IDLE;
        end else if (cnt == CNT_W'(TIMEOUT)) begin
          ret_valid = 1'b1;
          ret_err   = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_addr    <= '0;
      hold_wdata   <= '0;
      hold_reg_dst <= '0;
      hold_instr   <= '0;
      hold_we      <= 1'b0;
    end else if (capture) begin
      hold_addr    <= {alu_result[DATA_W-1:2], 2'b00};
      hold_wdata   <= reg2;
      hold_reg_dst <= reg_dst;
      hold_instr   <= instr;
      hold_we      <= (cmd == CMD_STORE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       cnt <= '0;
    else if (cnt_clr) cnt <= '0;
    else if (cnt_inc) cnt <= cnt + CNT_W'(1);
  end

  mem_wb_reg #(.DATA_W(DATA_W), .REG_W(REG_W)) u_wb (
    .clk        (clk),
    .rst_n      (rst_n),
    .retire     (ret_valid),
    .we_d       (ret_we),
    .err_d      (ret_err),
    .reg_dst_d  (ret_reg_dst),
    .data_d     (ret_data),
    .instr_d    (ret_instr),
    .wb_valid   (wb_valid),
    .wb_we      (wb_we),
    .err_o      (err_o),
    .wb_reg_dst (wb_reg_dst),
    .wb_data    (wb_data),
    .wb_instr   (wb_instr)
  );

endmodule

// File: tb/tb_mem_stage.sv
`timescale 1ns/1ps
module tb_mem_stage;
  import mem_pkg::*;

  localparam int DATA_W  = 32;
  localparam int REG_W   = 5;
  localparam int TIMEOUT = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] alu_result = '0;
  logic [DATA_W-1:0] reg2 = '0;
  logic [REG_W-1:0]  reg_dst = '0;
  logic [31:0]       instr = '0;
  logic              alu_write = 1'b0;
  logic [1:0]        cmd_type = 2'b00;
  logic              stall_o;
  logic              dmem_req_valid;
  logic              dmem_req_ready = 1'b0;
  logic              dmem_req_we;
  logic [DATA_W-1:0] dmem_req_addr;
  logic [DATA_W-1:0] dmem_req_wdata;
  logic              dmem_resp_valid = 1'b0;
  logic [DATA_W-1:0] dmem_resp_rdata = '0;
  logic              wb_valid;
  logic              wb_we;
  logic [REG_W-1:0]  wb_reg_dst;
  logic [DATA_W-1:0] wb_data;
  logic [31:0]       wb_instr;
  logic              err_o;
  state_e            dbg_state;

  mem_stage #(.DATA_W(DATA_W), .REG_W(REG_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .alu_result(alu_result),
    .reg2(reg2), .reg_dst(reg_dst), .instr(instr), .alu_write(alu_write),
    .cmd_type(cmd_type), .stall_o(stall_o), .dmem_req_valid(dmem_req_valid),
    .dmem_req_ready(dmem_req_ready), .dmem_req_we(dmem_req_we),
    .dmem_req_addr(dmem_req_addr), .dmem_req_wdata(dmem_req_wdata),
    .dmem_resp_valid(dmem_resp_valid), .dmem_resp_rdata(dmem_resp_rdata),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_reg_dst(wb_reg_dst),
    .wb_data(wb_data), .wb_instr(wb_instr), .err_o(err_o), .dbg_state(dbg_state)
  );

  // ---------------- model state / scoreboard ----------------
  typedef struct {
    int                due;
    logic              we;
    logic              err;
    logic              chk_rd;
    logic              chk_data;
    logic              chk_instr;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
    logic [31:0]       instr;
  } exp_t;

  exp_t exp_q[$];
  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int stall_from = 0, stall_to = -1;
  int req_from = 0, req_to = -1;
  logic [DATA_W-1:0] exp_addr = '0, exp_wdata = '0;
  logic exp_we = 1'b0;
  int last_wb_cyc = -1;
  int req_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------- compare process ----------------
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (wb_valid === 1'b1) last_wb_cyc = cyc;
      if (dmem_req_valid === 1'b1) req_cnt++;
      check("stall_o", stall_o, (cyc >= stall_from && cyc <= stall_to));
      check("req_valid", dmem_req_valid, (cyc >= req_from && cyc <= req_to));
      if (cyc >= req_from && cyc <= req_to) begin
        check("req_addr", dmem_req_addr, exp_addr);
        check("req_we", dmem_req_we, exp_we);
        if (exp_we) check("req_wdata", dmem_req_wdata, exp_wdata);
      end
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        e = exp_q.pop_front();
        check("wb_valid", wb_valid, 1'b1);
        check("wb_we", wb_we, e.we);
        check("err_o", err_o, e.err);
        if (e.chk_rd)    check("wb_reg_dst", wb_reg_dst, e.rd);
        if (e.chk_data)  check("wb_data", wb_data, e.data);
        if (e.chk_instr) check("wb_instr", wb_instr, e.instr);
      end else begin
        check("wb_valid_quiet", wb_valid, 1'b0);
        check("err_o_quiet", err_o, 1'b0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge while the stage is idle; returns at the negedge of the
  // cycle in which the instruction's writeback (and any late response) shows.
  task automatic run_op(input logic [1:0] cmd, input logic [DATA_W-1:0] addr,
                        input logic [DATA_W-1:0] wdata, input logic [REG_W-1:0] rd,
                        input logic [31:0] ins, input logic aw, input int r,
                        input int d, input logic [DATA_W-1:0] rdata);
    exp_t e;
    int n, last, resp_at;
    logic is_mem, bad;
    n = cyc + 1;
    in_valid = 1'b1; alu_result = addr; reg2 = wdata; reg_dst = rd;
    instr = ins; alu_write = aw; cmd_type = cmd;
    dmem_req_ready = 1'($urandom_range(0, 1));
    is_mem = (cmd == CMD_LOAD) || (cmd == CMD_STORE);
    bad = (cmd == CMD_RSVD) || (is_mem && addr[1:0] != 2'b00);
    e.due = n; e.we = 1'b0; e.err = 1'b0; e.chk_rd = 1'b0; e.chk_data = 1'b0;
    e.chk_instr = 1'b0; e.rd = rd; e.data = addr; e.instr = ins;
    resp_at = -1;
    if (cmd == CMD_ALU) begin
      e.we = aw && (rd != 0);
      e.chk_rd = 1'b1; e.chk_data = 1'b1; e.chk_instr = 1'b1;
    end else if (bad) begin
      e.err = 1'b1;
    end else begin
      req_from = n; req_to = n + r;
      exp_addr = addr; exp_wdata = wdata; exp_we = (cmd == CMD_STORE);
      if (cmd == CMD_STORE) begin
        e.due = n + r + 1;
        e.chk_instr = 1'b1;
      end else begin
        resp_at = n + r + d;
        if (d <= TIMEOUT + 1) begin
          e.due = n + r + 1 + d;
          e.we = (rd != 0); e.data = rdata;
          e.chk_rd = 1'b1; e.chk_data = 1'b1; e.chk_instr = 1'b1;
        end else begin
          e.due = n + r + TIMEOUT + 2;
          e.err = 1'b1;
        end
      end
      stall_from = n; stall_to = e.due - 1;
    end
    exp_q.push_back(e);
    last = (resp_at > e.due) ? resp_at : e.due;
    while (cyc < last) begin
      @(negedge clk);
      in_valid = 1'b0; alu_result = $urandom; reg2 = $urandom; reg_dst = REG_W'($urandom);
      instr = $urandom; cmd_type = 2'($urandom); alu_write = 1'($urandom);
      dmem_req_ready = (cyc < n + r) ? 1'b0 : (cyc == n + r) ? 1'b1 : 1'($urandom_range(0, 1));
      dmem_resp_valid = (cyc == resp_at);
      dmem_resp_rdata = (cyc == resp_at) ? rdata : $urandom;
    end
  endtask

  task automatic run_idle();
    @(negedge clk);
    in_valid = 1'b0; alu_result = $urandom; cmd_type = 2'($urandom);
    dmem_req_ready = 1'($urandom_range(0, 1));
    dmem_resp_valid = 1'($urandom_range(0, 1));
    dmem_resp_rdata = $urandom;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t0, n, k;
    logic [1:0] c;
    logic [DATA_W-1:0] a;
    logic [REG_W-1:0] rd;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("rst_stall", stall_o, 1'b0);
    check("rst_req_valid", dmem_req_valid, 1'b0);
    check("rst_state", dbg_state, ST_IDLE);
    check("rst_wb_valid", wb_valid, 1'b0);
    check("rst_wb_we", wb_we, 1'b0);
    check("rst_err", err_o, 1'b0);
    check("rst_wb_data", wb_data, 0);
    check("rst_wb_reg_dst", wb_reg_dst, 0);
    check("rst_wb_instr", wb_instr, 0);
    check("rst_req_addr", dmem_req_addr, 0);
    check("rst_req_wdata", dmem_req_wdata, 0);

    // ALU op: one-cycle latency, no stall
    t0 = cyc;
    run_op(CMD_ALU, 32'h1234, 32'h0, 5'd3, 32'hA1, 1'b1, 0, 1, 32'h0);
    check("alu_latency", last_wb_cyc - t0, 1);
    check("alu_data_lit", wb_data, 32'h1234);
    check("alu_rd_lit", wb_reg_dst, 3);
    check("alu_we_lit", wb_we, 1'b1);

    // ALU op to register 0: write suppressed
    run_op(CMD_ALU, 32'h99, 32'h0, 5'd0, 32'hA0, 1'b1, 0, 1, 32'h0);
    check("alu_r0_we_lit", wb_we, 1'b0);

    // Load: ready immediately, response two cycles after accept
    req_cnt = 0; t0 = cyc;
    run_op(CMD_LOAD, 32'h100, 32'h0, 5'd7, 32'hA2, 1'b0, 0, 2, 32'hDEADBEEF);
    check("load_latency", last_wb_cyc - t0, 4);
    check("load_req_cycles", req_cnt, 1);
    check("load_data_lit", wb_data, 32'hDEADBEEF);
    check("load_we_lit", wb_we, 1'b1);

    // Store: ready low for three cycles
    req_cnt = 0; t0 = cyc;
    run_op(CMD_STORE, 32'h40, 32'hCAFE, 5'd2, 32'hA3, 1'b0, 3, 1, 32'h0);
    check("store_latency", last_wb_cyc - t0, 5);
    check("store_req_cycles", req_cnt, 4);
    check("store_we_lit", wb_we, 1'b0);

    // Misaligned load, then reserved command
    req_cnt = 0; t0 = cyc;
    run_op(CMD_LOAD, 32'h102, 32'h0, 5'd6, 32'hA4, 1'b0, 0, 1, 32'h0);
    check("misalign_latency", last_wb_cyc - t0, 1);
    check("misalign_err_lit", err_o, 1'b1);
    check("misalign_we_lit", wb_we, 1'b0);
    run_op(CMD_RSVD, 32'h200, 32'h0, 5'd6, 32'hA5, 1'b1, 0, 1, 32'h0);
    check("rsvd_err_lit", err_o, 1'b1);
    check("rsvd_req_cycles", req_cnt, 0);

    // Timeout, followed by a late response that must be ignored
    t0 = cyc;
    run_op(CMD_LOAD, 32'h300, 32'h0, 5'd4, 32'hA6, 1'b0, 0, TIMEOUT + 3, 32'h55);
    check("timeout_latency", last_wb_cyc - t0, 7);
    run_idle(); run_idle();

    // Reset while waiting for a load response
    n = cyc + 1;
    in_valid = 1'b1; cmd_type = CMD_LOAD; alu_result = 32'h200; reg_dst = 5'd9;
    instr = 32'hA7; dmem_req_ready = 1'b0; dmem_resp_valid = 1'b0;
    req_from = n; req_to = n; exp_addr = 32'h200; exp_we = 1'b0;
    stall_from = n; stall_to = n + 2;
    @(negedge clk); in_valid = 1'b0; dmem_req_ready = 1'b1;
    @(negedge clk); dmem_req_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_stall", stall_o, 1'b0);
    check("midrst_req_valid", dmem_req_valid, 1'b0);
    check("midrst_state", dbg_state, ST_IDLE);
    check("midrst_wb_valid", wb_valid, 1'b0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    run_op(CMD_ALU, 32'h77, 32'h0, 5'd5, 32'hA8, 1'b1, 0, 1, 32'h0);
    check("postrst_data_lit", wb_data, 32'h77);

    // Randomized traffic
    for (int i = 0; i < 80; i++) begin
      k = $urandom_range(0, 9);
      if (k == 0) begin
        run_idle();
      end else begin
        c = (k <= 2) ? CMD_ALU : (k <= 5) ? CMD_LOAD : (k <= 8) ? CMD_STORE : CMD_RSVD;
        a = $urandom;
        if ($urandom_range(0, 4) != 0) a[1:0] = 2'b00;
        rd = ($urandom_range(0, 3) == 0) ? '0 : REG_W'($urandom);
        run_op(c, a, $urandom, rd, $urandom, 1'($urandom_range(0, 1)),
               $urandom_range(0, 3), $urandom_range(1, TIMEOUT + 3), $urandom);
      end
    end
    run_idle(); run_idle(); run_idle();
    check("exp_q_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: actual=timeout required=finish (cycle %0d)", cyc);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
